mips32_fetch_queue: RTL
=======================

// Module: mips32_fetch_queue
// PURPOSE
//  Instruction prefetch queue that sits directly upstream of the MIPS32 decode stage.
//  Fetches word-addressed instructions from instruction memory over a req/ack handshake.
//  Buffers them with their NPC and presents them to decode over valid/ready.
//  Flushes and restarts on a taken-branch redirect from the execute stage.
// PARAMETERS
//  DEPTH  4   queue entries (power of 2, >=2)
//  AW     10  instruction memory word-address width (1024-word memory)
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  redirect     in   1   taken branch; restart fetch at redirect_pc
//  redirect_pc  in   32  branch target (word address)
//  imem_req     out  1   fetch request; held with imem_addr stable until imem_ack
//  imem_addr    out  AW  fetch word address = fetch_pc[AW-1:0]
//  imem_ack     in   1   imem_rdata valid this cycle (same cycle as req or later)
//  imem_rdata   in   32  fetched instruction
//  id_valid     out  1   head entry valid
//  id_ready     in   1   decode accepts head this cycle
//  id_ir        out  32  head instruction
//  id_npc       out  32  head NPC (fetch address + 1)
//  q_count      out  $clog2(DEPTH+1)  occupied entries
//  halted       out  1   fetch stopped on HLT (see CONFIGURATION)
// BEHAVIOUR
//  Reset: fetch_pc=0, q_count=0, imem_req=0, id_valid=0, halted=0, drop=0, FSM=IDLE.
//  Entry: {ir, npc}. npc = fetch_pc+1, full 32-bit. imem_addr wraps modulo 2^AW; npc does not wrap.
//  One outstanding request maximum. Issue only if q_count + outstanding < DEPTH (no overflow possible).
//  FSM IDLE: if space, assert imem_req next cycle -> WAIT.
//  FSM WAIT: on imem_ack -> enqueue (unless drop), fetch_pc+=1.
//   - If space remains, stay in WAIT with new address (back-to-back); otherwise -> IDLE.
//  FSM STOP: no requests (macro only). Left only via redirect or rst.
//  Throughput: 1 instr/cycle when ack is same-cycle and decode is ready.
//  Latency: rst release -> imem_req in cycle 1. With same-cycle ack, id_valid in cycle 2.
//  Output: id_valid = (q_count!=0); id_ir/id_npc come from the head, combinational from storage.
//   - Dequeue on id_valid && id_ready. Simultaneous enq+deq leaves q_count unchanged.
//  Redirect (priority over enq/deq):
//   - Queue emptied next cycle (q_count=0, id_valid=0); fetch_pc <= redirect_pc; FSM leaves STOP.
//   - If a request is outstanding and unacked, imem_req/addr are held until ack. That response is
//     discarded (drop=1), then fetch resumes at redirect_pc.
//   - If ack arrives in the redirect cycle, that data is discarded.
//   - Redirect in consecutive cycles: last target wins.
//  Reset mid-transaction: imem_req drops next cycle; any late ack is ignored (FSM IDLE).
// CONFIGURATION
//  MIPS32_IFQ_HALT_DETECT_EN defined:
//   - When an enqueued ir[31:26]==6'b111111 (HLT), FSM -> STOP and halted=1 the next cycle.
//   - Entries already queued still drain to decode.
//   - Redirect clears halted and restarts fetch, since the HLT may be on the wrong path.
//  Undefined: HLT is queued like any other word; halted tied 0; STOP unreachable.
// TESTING
//  1. Mem[0..3]=A,B,C,D; same-cycle ack; id_ready=1 -> A/1,B/2,C/3,D/4 on consecutive cycles from cycle 2.
//  2. id_ready=0 -> q_count=4, imem_req=0. Raise id_ready -> A,B,C,D in order, then fetch resumes at addr 4.
//  3. Ack delay 3; redirect, redirect_pc=0x40, while addr 5 is outstanding -> stale word dropped;
//     next id_ir=Mem[0x40], id_npc=0x41.
//  4. Redirect coincides with ack and dequeue -> q_count=0 next cycle; no stale entry ever reaches id_valid.
//  5. redirect_pc=0x3FF -> imem_addr 0x3FF then 0x000; id_npc 0x400 then 0x401.
//  6. Macro on, Mem[2]=32'hFC000000 -> halted=1 after enqueue, imem_req stays 0, words 0..2 drain.
//     Redirect to 0x10 -> halted=0, fetch at 0x10.

Source files
------------

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: instruction prefetch queue feeding the MIPS32 decode stage.
// Fetches word-addressed instructions over a req/ack handshake. Buffers each
// instruction with its NPC and presents the oldest one to decode over valid/ready.
// A taken-branch redirect flushes the queue and restarts fetch at the branch target.
//
// Optional feature: define MIPS32_IFQ_HALT_DETECT_EN to stop fetching after a
// HLT word (ir[31:26] == 6'b111111) is enqueued.
//
// state | meaning
// IDLE  | no request outstanding; issue one when the queue has room
// WAIT  | request outstanding; imem_req/imem_addr held until imem_ack
// STOP  | HLT seen, no further requests until redirect (halt-detect build only)

module mips32_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         imem_req,
  output logic [AW-1:0]                imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [31:0]                  id_ir,
  output logic [31:0]                  id_npc,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         halted
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx, fetch_pc_inc;
  logic [AW-1:0] req_addr, req_addr_nx;
  logic          drop, drop_nx;
  logic          halted_q, halted_nx;

  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   npc_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_after;

  logic          enq, deq, hlt_word;

`ifdef MIPS32_IFQ_HALT_DETECT_EN
  assign hlt_word = (imem_rdata[31:26] == 6'b111111);
`else
  assign hlt_word = 1'b0;
`endif

  // While drop is set, fetch_pc already holds the redirect target and the
  // outstanding request is for the old path, so its data is never enqueued.
  assign fetch_pc_inc = fetch_pc + 32'd1;
  assign deq          = id_valid && id_ready && !redirect;
  assign enq          = (state == WAIT) && imem_ack && !drop && !redirect;
  assign count_after  = count + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, deq};

  assign imem_req  = (state == WAIT);
  assign imem_addr = req_addr;
  assign id_valid  = (count != '0);
  assign id_ir     = ir_mem[rd_ptr];
  assign id_npc    = npc_mem[rd_ptr];
  assign q_count   = count;
  assign halted    = halted_q;

  // FSM state and fetch-address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= 32'd0;
      req_addr <= '0;
      drop     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
      drop     <= drop_nx;
      halted_q <= halted_nx;
    end
  end

  // Next-state logic; redirect overrides normal fetch progress
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    drop_nx     = drop;
    halted_nx   = halted_q;
    if (redirect) begin
      fetch_pc_nx = redirect_pc;
      halted_nx   = 1'b0;
      if ((state == WAIT) && !imem_ack) begin
        // keep the bus request stable; its response belongs to the old path
        state_nx = WAIT;
        drop_nx  = 1'b1;
      end else begin
        state_nx = IDLE;
        drop_nx  = 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            state_nx    = WAIT;
            req_addr_nx = fetch_pc[AW-1:0];
          end
        end
        WAIT: begin
          if (imem_ack) begin
            if (drop) begin
              drop_nx = 1'b0;
            end else begin
              fetch_pc_nx = fetch_pc_inc;
            end
            if (enq && hlt_word) begin
              state_nx  = STOP;
              halted_nx = 1'b1;
            end else if (count_after < DEPTH_C) begin
              state_nx    = WAIT;
              req_addr_nx = fetch_pc_nx[AW-1:0];
            end else begin
              state_nx = IDLE;
            end
          end
        end
        STOP: begin
          state_nx = STOP;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; reset and redirect both empty the queue
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

  // Queue storage: instruction word and its full 32-bit NPC
  always_ff @(posedge clk) begin
    if (enq) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= fetch_pc_inc;
    end
  end

endmodule
